// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic phase sequencer: state encoding,
// one-hot lamp codes {red,yellow,green} and the default phase durations.
package tlc_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    WALK      = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam int DEF_GREEN_TIME  = 10;
  localparam int DEF_YELLOW_TIME = 3;
  localparam int DEF_ALLRED_TIME = 1;
  localparam int DEF_WALK_TIME   = 5;
  localparam int DEF_SHORT_GREEN = 3;
  localparam int DEF_CNT_W       = 6;

  // Direction whose green follows the next all-red / walk phase.
  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  function automatic int phase_duration(input state_t s, input int green_time,
                                        input int yellow_time, input int allred_time,
                                        input int walk_time);
    case (s)
      NS_GREEN, EW_GREEN:   phase_duration = green_time;
      NS_YELLOW, EW_YELLOW: phase_duration = yellow_time;
      WALK:                 phase_duration = walk_time;
      default:              phase_duration = allred_time;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase down-counter: loads a value, decrements on each enable tick while
// non-zero, and flags zero so the sequencer knows the phase is on its last tick.
module phase_timer #(
  parameter int              CNT_W      = 6,
  parameter logic [CNT_W-1:0] INIT_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  // A load always wins over a decrement on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= INIT_VALUE;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/traffic_phase_fsm.sv
// Traffic-light phase sequencer driven by the 1 Hz Divider tick, with latched
// pedestrian requests. Define TLC_PED_SHORTEN_EN to cut a green short on request.
module traffic_phase_fsm
  import tlc_pkg::*;
#(
  parameter int GREEN_TIME  = DEF_GREEN_TIME,
  parameter int YELLOW_TIME = DEF_YELLOW_TIME,
  parameter int ALLRED_TIME = DEF_ALLRED_TIME,
  parameter int WALK_TIME   = DEF_WALK_TIME,
  parameter int SHORT_GREEN = DEF_SHORT_GREEN,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             ped_request,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             walk,
  output logic             ped_pending,
  output logic [CNT_W-1:0] seconds_left,
  output logic             timer_reset
);

  if (GREEN_TIME < 1 || YELLOW_TIME < 1 || ALLRED_TIME < 1 || WALK_TIME < 1 ||
      GREEN_TIME > 2**CNT_W || YELLOW_TIME > 2**CNT_W ||
      ALLRED_TIME > 2**CNT_W || WALK_TIME > 2**CNT_W) begin : g_bad_duration
    $error("traffic_phase_fsm: phase durations must be >=1 and fit in CNT_W bits");
  end
  if (SHORT_GREEN < 1 || SHORT_GREEN > GREEN_TIME) begin : g_bad_short_green
    $error("traffic_phase_fsm: SHORT_GREEN must lie in 1..GREEN_TIME");
  end

  state_t           state_reg, state_next;
  logic             next_dir_reg, next_dir_next;
  logic             ped_pending_reg, ped_pending_next;
  logic             timer_reset_reg;
  logic             phase_done;
  logic             timer_load;
  logic [CNT_W-1:0] timer_load_value;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  phase_timer #(
    .CNT_W      (CNT_W),
    .INIT_VALUE (CNT_W'(ALLRED_TIME - 1))
  ) u_phase_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .load       (timer_load),
    .load_value (timer_load_value),
    .count      (cnt),
    .zero       (cnt_zero)
  );

  assign phase_done = enable && cnt_zero;

  always_comb begin
    state_next    = state_reg;
    next_dir_next = next_dir_reg;
    if (phase_done) begin
      case (state_reg)
        NS_GREEN:  state_next = NS_YELLOW;
        NS_YELLOW: state_next = ALLRED_A;
        ALLRED_A: begin
          next_dir_next = DIR_EW;
          state_next    = ped_pending_reg ? WALK : EW_GREEN;
        end
        EW_GREEN:  state_next = EW_YELLOW;
        EW_YELLOW: state_next = ALLRED_B;
        ALLRED_B: begin
          next_dir_next = DIR_NS;
          state_next    = ped_pending_reg ? WALK : NS_GREEN;
        end
        WALK:      state_next = (next_dir_reg == DIR_EW) ? EW_GREEN : NS_GREEN;
        default:   state_next = ALLRED_B;
      endcase
    end
  end

  always_comb begin
    timer_load       = phase_done;
    timer_load_value = CNT_W'(phase_duration(state_next, GREEN_TIME, YELLOW_TIME,
                                             ALLRED_TIME, WALK_TIME) - 1);
`ifdef TLC_PED_SHORTEN_EN
    // Silent reload: the Divider is not realigned, so no timer_reset here.
    if (!phase_done && ped_pending_reg && (state_reg == NS_GREEN || state_reg == EW_GREEN) &&
        (cnt > CNT_W'(SHORT_GREEN - 1))) begin
      timer_load       = 1'b1;
      timer_load_value = CNT_W'(SHORT_GREEN - 1);
    end
`endif
  end

  always_comb begin
    ped_pending_next = ped_pending_reg;
    if (phase_done && state_next == WALK) begin
      ped_pending_next = 1'b0;
    end else if (ped_request && state_reg != WALK) begin
      ped_pending_next = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ALLRED_B;
      next_dir_reg    <= DIR_NS;
      ped_pending_reg <= 1'b0;
      timer_reset_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      next_dir_reg    <= next_dir_next;
      ped_pending_reg <= ped_pending_next;
      timer_reset_reg <= phase_done;
    end
  end

  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    walk     = 1'b0;
    case (state_reg)
      NS_GREEN:  ns_light = LAMP_GRN;
      NS_YELLOW: ns_light = LAMP_YEL;
      EW_GREEN:  ew_light = LAMP_GRN;
      EW_YELLOW: ew_light = LAMP_YEL;
      WALK:      walk     = 1'b1;
      default:   ;
    endcase
  end

  assign ped_pending  = ped_pending_reg;
  assign seconds_left = cnt;
  assign timer_reset  = timer_reset_reg;

endmodule
